// File: rtl/xrbus_tx_scheduler.sv
// XR-BUS transmit scheduler: arbitrates NREQ sources onto the single frame
// pipeline with starvation guard, urgent class and round-robin fairness,
// an inter-frame gap and a credit limit on frames in flight.
module xrbus_tx_scheduler #(
  parameter int unsigned NREQ            = 4,
  parameter int unsigned PW              = 1024,
  parameter int unsigned MAX_OUTSTANDING = 3,
  parameter int unsigned MIN_GAP         = 1,
  parameter int unsigned STARVE_LIMIT    = 64
) (
  input  logic                 device_clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_urgent,
  input  logic [NREQ*16-1:0]   req_module_id,
  input  logic [NREQ*16-1:0]   req_boundary_id,
  input  logic [NREQ*8-1:0]    req_op_code,
  input  logic [NREQ*PW-1:0]   req_payload,
  input  logic [NREQ*10-1:0]   req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_request,
  output logic [15:0]          tx_module_id,
  output logic [15:0]          tx_boundary_id,
  output logic [7:0]           tx_op_code,
  output logic [PW-1:0]        tx_payload,
  output logic [9:0]           tx_payload_len,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic [3:0]           credits,
  output logic                 arb_busy,
  output logic                 starve_event,
  output logic                 len_clamp,
  output logic                 credit_err
);

  localparam int unsigned IDW     = 16;
  localparam int unsigned OPW     = 8;
  localparam int unsigned LW      = 10;
  localparam int unsigned CW      = 4;
  localparam int unsigned GW      = 3;
  localparam int unsigned SCW     = 8;
  localparam int unsigned GAPW    = 4;
  localparam int unsigned MAX_LEN = PW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t            state_q, state_d;
  logic [GAPW-1:0]   gap_q, gap_d;
  logic [GW-1:0]     rr_ptr_q;
  logic [SCW-1:0]    wait_q [NREQ];
  logic [NREQ-1:0]   starved;
  logic              take;
  logic              win_found;
  logic              win_starved;
  logic [GW-1:0]     win_idx;
  int unsigned       idx;
  logic [IDW-1:0]    sel_mod;
  logic [IDW-1:0]    sel_bnd;
  logic [OPW-1:0]    sel_op;
  logic [PW-1:0]     sel_pl;
  logic [LW-1:0]     sel_len;
  logic              sel_clamp;

  // A pending source is starved once its wait counter reaches the limit
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      starved[i] = req_valid[i] && (wait_q[i] >= SCW'(STARVE_LIMIT));
    end
  end

  // Winner: lowest starved, else urgent round-robin, else plain round-robin
  always_comb begin
    win_found   = 1'b0;
    win_starved = 1'b0;
    win_idx     = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && starved[i]) begin
        win_found   = 1'b1;
        win_starved = 1'b1;
        win_idx     = GW'(i);
      end
    end
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req_valid[idx] && req_urgent[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // Select the winner's frame fields and apply the length clamp
  always_comb begin
    sel_mod = '0;
    sel_bnd = '0;
    sel_op  = '0;
    sel_pl  = '0;
    sel_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == GW'(i)) begin
        sel_mod = req_module_id[IDW*i +: IDW];
        sel_bnd = req_boundary_id[IDW*i +: IDW];
        sel_op  = req_op_code[OPW*i +: OPW];
        sel_pl  = req_payload[PW*i +: PW];
        sel_len = req_len[LW*i +: LW];
      end
    end
    sel_clamp = (sel_len > LW'(MAX_LEN));
  end

  // FSM state register
  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // FSM next state and grant decision
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|req_valid) && (credits != '0)) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = GAPW'(MIN_GAP);
        state_d = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q <= GAPW'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAPW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue strobes, latched frame fields, grant pointer and credit accounting
  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready      <= '0;
      tx_request     <= 1'b0;
      tx_module_id   <= '0;
      tx_boundary_id <= '0;
      tx_op_code     <= '0;
      tx_payload     <= '0;
      tx_payload_len <= '0;
      grant_id       <= '0;
      rr_ptr_q       <= GW'(NREQ - 1);
      credits        <= CW'(MAX_OUTSTANDING);
      arb_busy       <= 1'b0;
      starve_event   <= 1'b0;
      len_clamp      <= 1'b0;
      credit_err     <= 1'b0;
    end else begin
      tx_request   <= take;
      req_ready    <= take ? (NREQ'(1) << win_idx) : '0;
      starve_event <= take && win_starved;
      len_clamp    <= take && sel_clamp;
      arb_busy     <= (state_d != IDLE);
      if (take) begin
        tx_module_id   <= sel_mod;
        tx_boundary_id <= sel_bnd;
        tx_op_code     <= sel_op;
        tx_payload     <= sel_pl;
        tx_payload_len <= sel_clamp ? LW'(MAX_LEN) : sel_len;
        grant_id       <= win_idx;
        rr_ptr_q       <= win_idx;
      end
      if ((state_q == ISSUE) && !tx_done) begin
        credits <= credits - CW'(1);
      end else if ((state_q != ISSUE) && tx_done) begin
        if (credits == CW'(MAX_OUTSTANDING)) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CW'(1);
        end
      end
    end
  end

  // Per-source wait counters: count while pending and not being granted
  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i] || (take && (win_idx == GW'(i)))) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != '1) begin
          wait_q[i] <= wait_q[i] + SCW'(1);
        end
      end
    end
  end

endmodule
